// File: rtl/wb_bus_arbiter.sv
// wb_bus_arbiter: round-robin arbiter sharing one strobe/ack slave bus among NM masters
module wb_bus_arbiter #(
  parameter int NM        = 2,
  parameter int AW        = 8,
  parameter int DW        = 8,
  parameter int MAX_BURST = 16,
  parameter int TIMEOUT   = 255
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic [NM-1:0]    m_stb_i,
  input  logic [NM-1:0]    m_we_i,
  input  logic [NM*AW-1:0] m_adr_i,
  input  logic [NM*DW-1:0] m_dat_i,
  output logic [NM-1:0]    m_ack_o,
  output logic [NM-1:0]    m_err_o,
  output logic [DW-1:0]    m_dat_o,
  output logic             s_stb_o,
  output logic             s_we_o,
  output logic [AW-1:0]    s_adr_o,
  output logic [DW-1:0]    s_dat_o,
  input  logic             s_ack_i,
  input  logic [DW-1:0]    s_dat_i,
  output logic [NM-1:0]    gnt_o
);
  typedef enum logic [1:0] {IDLE, BUSY, ERR} state_t;
  state_t        r_state;
  logic [NM-1:0] r_gnt;
  logic [1:0]    r_g, r_rr;
  logic [7:0]    r_burst, r_to;
  logic [1:0]    w_pick_lo, w_pick_hi, w_pick, w_next_rr;
  logic          w_hi, w_busy, w_stb_g, w_others, w_release;
  logic [7:0]    w_burst_inc, w_to_inc;
  logic [AW-1:0] w_adr;
  logic [DW-1:0] w_dat;
  assign w_busy      = r_state == BUSY;
  assign w_stb_g     = |(m_stb_i & r_gnt);
  assign w_others    = |(m_stb_i & ~r_gnt);
  assign w_burst_inc = (r_burst == 8'(MAX_BURST)) ? r_burst : r_burst + 8'd1;
  assign w_to_inc    = r_to + 8'd1;
  assign w_next_rr   = (r_g == 2'(NM-1)) ? 2'd0 : r_g + 2'd1;
  assign w_pick      = w_hi ? w_pick_hi : w_pick_lo;
  assign w_release   = !w_stb_g || (s_ack_i && w_burst_inc == 8'(MAX_BURST) && w_others);
  assign gnt_o       = r_gnt;
  assign s_stb_o     = w_busy & w_stb_g;
  assign s_we_o      = w_busy & |(m_we_i & r_gnt);
  assign s_adr_o     = w_busy ? w_adr : '0;
  assign s_dat_o     = w_busy ? w_dat : '0;
  assign m_dat_o     = w_busy ? s_dat_i : '0;
  assign m_ack_o     = (w_busy & s_ack_i) ? (m_stb_i & r_gnt) : '0;
  assign m_err_o     = (r_state == ERR) ? r_gnt : '0;
  // round-robin pick: lowest requester at or above rr_ptr, else lowest overall (wrap)
  always_comb begin
    w_pick_lo = '0;
    w_pick_hi = '0;
    w_hi      = 1'b0;
    for (int i = NM-1; i >= 0; i--) begin
      if (m_stb_i[i]) w_pick_lo = 2'(i);
      if (m_stb_i[i] && 2'(i) >= r_rr) begin
        w_pick_hi = 2'(i);
        w_hi      = 1'b1;
      end
    end
  end
  // address/data mux driven by the one-hot grant
  always_comb begin
    w_adr = '0;
    w_dat = '0;
    for (int i = 0; i < NM; i++)
      if (r_gnt[i]) begin
        w_adr = m_adr_i[i*AW +: AW];
        w_dat = m_dat_i[i*DW +: DW];
      end
  end
  // arbitration FSM with burst limit and ack watchdog
  always_ff @(posedge clk_i)
    if (rst_i) begin
      r_state <= IDLE;
      r_gnt   <= '0;
      r_g     <= '0;
      r_rr    <= '0;
      r_burst <= '0;
      r_to    <= '0;
    end else begin
      case (r_state)
        IDLE: if (|m_stb_i) begin
          r_state <= BUSY;
          r_gnt   <= {{(NM-1){1'b0}}, 1'b1} << w_pick;
          r_g     <= w_pick;
          r_burst <= '0;
          r_to    <= '0;
        end
        BUSY: if (w_release) begin
          r_state <= IDLE;
          r_gnt   <= '0;
          r_rr    <= w_next_rr;
        end else if (s_ack_i) begin
          r_burst <= w_burst_inc;
          r_to    <= '0;
        end else begin
          r_to    <= w_to_inc;
          if (w_to_inc == 8'(TIMEOUT)) r_state <= ERR;
        end
        ERR: begin
          r_state <= IDLE;
          r_gnt   <= '0;
          r_rr    <= w_next_rr;
        end
        default: r_state <= IDLE;
      endcase
    end
endmodule

// File: tb/tb_wb_bus_arbiter.sv
// tb_wb_bus_arbiter: directed scenarios plus random soak against a behavioural bus model
module tb_wb_bus_arbiter;
  localparam int NM = 2, AW = 8, DW = 8, MB = 16, TO = 255, NT = 256;
  logic clk = 1'b0, rst;
  logic [NM-1:0] m_stb, m_we, m_ack, m_err, gnt;
  logic [NM*AW-1:0] m_adr;
  logic [NM*DW-1:0] m_dat;
  logic [DW-1:0] m_rdat, s_wdat, s_rdat;
  logic [AW-1:0] s_adr;
  logic s_stb, s_we, s_ack;
  int n_cmp = 0, n_bad = 0;
  int ms = 0, mg = 0, mrr = 0, mbc = 0, mtc = 0;
  logic [AW-1:0] q_adr[NM][NT];
  logic [DW-1:0] q_dat[NM][NT];
  logic q_we[NM][NT];
  int idx[NM], gap[NM], sl_wait, cnt, cyc;
  wb_bus_arbiter #(.NM(NM), .AW(AW), .DW(DW), .MAX_BURST(MB), .TIMEOUT(TO)) dut (
    .clk_i(clk), .rst_i(rst), .m_stb_i(m_stb), .m_we_i(m_we), .m_adr_i(m_adr),
    .m_dat_i(m_dat), .m_ack_o(m_ack), .m_err_o(m_err), .m_dat_o(m_rdat),
    .s_stb_o(s_stb), .s_we_o(s_we), .s_adr_o(s_adr), .s_dat_o(s_wdat),
    .s_ack_i(s_ack), .s_dat_i(s_rdat), .gnt_o(gnt));
  always #5 clk = ~clk;
  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask
  task automatic model_check();
    logic busy, sg;
    busy = ms == 1;
    sg = busy && m_stb[mg];
    check("gnt", 32'(gnt), ms != 0 ? 1 << mg : 0);
    check("s_stb", 32'(s_stb), 32'(sg));
    check("s_we", 32'(s_we), busy ? 32'(m_we[mg]) : 0);
    check("s_adr", 32'(s_adr), busy ? 32'(m_adr[mg*AW +: AW]) : 0);
    check("s_dat", 32'(s_wdat), busy ? 32'(m_dat[mg*DW +: DW]) : 0);
    check("m_ack", 32'(m_ack), (sg && s_ack) ? 1 << mg : 0);
    check("m_err", 32'(m_err), ms == 2 ? 1 << mg : 0);
    check("m_dat", 32'(m_rdat), busy ? 32'(s_rdat) : 0);
  endtask
  task automatic model_update();
    int o, found;
    o = 0;
    found = 0;
    if (rst) begin
      ms = 0; mg = 0; mrr = 0; mbc = 0; mtc = 0;
    end else if (ms == 0) begin
      for (int i = 0; i < NM; i++)
        if (!found && m_stb[(mrr + i) % NM]) begin
          mg = (mrr + i) % NM;
          found = 1;
        end
      if (found) begin ms = 1; mbc = 0; mtc = 0; end
    end else if (ms == 1) begin
      for (int i = 0; i < NM; i++) if (i != mg && m_stb[i]) o = 1;
      if (!m_stb[mg]) begin
        ms = 0; mrr = (mg + 1) % NM;
      end else if (s_ack) begin
        mbc = mbc < MB ? mbc + 1 : MB;
        mtc = 0;
        if (mbc == MB && o) begin ms = 0; mrr = (mg + 1) % NM; end
      end else begin
        mtc++;
        if (mtc == TO) ms = 2;
      end
    end else begin
      ms = 0; mrr = (mg + 1) % NM;
    end
  endtask
  task automatic step();
    @(negedge clk);
    model_check();
    model_update();
    @(posedge clk);
    #1;
  endtask
  task automatic do_reset();
    rst = 1'b1; m_stb = '0; s_ack = 1'b0;
    step();
    rst = 1'b0;
  endtask
  initial begin
    rst = 1'b1; m_stb = '0; m_we = '0; m_adr = '0; m_dat = '0; s_ack = 1'b0; s_rdat = '0;
    @(posedge clk);
    #1;
    step();
    #1;
    check("rst_gnt", 32'(gnt), 0);
    check("rst_stb", 32'(s_stb), 0);
    rst = 1'b0;
    step();
    // T1 single read
    m_stb = 2'b01; m_adr[7:0] = 8'h3C; m_we = '0;
    step();
    #1 check("t1_gnt", 32'(gnt), 1);
    step();
    s_ack = 1'b1; s_rdat = 8'hA5;
    #1;
    check("t1_ack", 32'(m_ack), 1);
    check("t1_mdat", 32'(m_rdat), 32'hA5);
    check("t1_adr", 32'(s_adr), 32'h3C);
    step();
    m_stb = '0; s_ack = 1'b0;
    step();
    #1 check("t1_idle", 32'(gnt), 0);
    step();
    // T2 contention
    do_reset();
    m_stb = 2'b11;
    step();
    #1 check("t2_first", 32'(gnt), 1);
    step();
    m_stb = 2'b10;
    step();
    #1 check("t2_gap", 32'(gnt), 0);
    step();
    #1 check("t2_second", 32'(gnt), 2);
    m_stb = '0;
    step();
    step();
    // T3 burst limit with a waiter, then without
    do_reset();
    m_stb = 2'b11; s_ack = 1'b1; cnt = 0;
    for (int c = 0; c < 60 && gnt !== 2'b10; c++) begin
      if (m_ack[0]) cnt++;
      step();
    end
    check("t3_acks", 32'(cnt), 16);
    check("t3_handover", 32'(gnt), 2);
    do_reset();
    m_stb = 2'b01; s_ack = 1'b1; cnt = 0;
    for (int c = 0; c < 40; c++) begin
      if (m_ack[0]) cnt++;
      step();
    end
    check("t3_noidle_acks", 32'(cnt), 39);
    check("t3_noidle_gnt", 32'(gnt), 1);
    m_stb = '0; s_ack = 1'b0;
    step();
    step();
    // T4 timeout on M1
    do_reset();
    m_stb = 2'b10; cnt = 0;
    for (int c = 0; c < 400 && !m_err[1]; c++) begin
      if (s_stb) cnt++;
      step();
    end
    check("t4_busy", 32'(cnt), 255);
    check("t4_err", 32'(m_err), 2);
    check("t4_stb_low", 32'(s_stb), 0);
    m_stb = 2'b11;
    step();
    step();
    #1 check("t4_rr", 32'(gnt), 1);
    m_stb = '0;
    step();
    step();
    // T5 reset mid-burst
    do_reset();
    m_stb = 2'b01; s_ack = 1'b1;
    repeat (5) step();
    rst = 1'b1;
    step();
    #1;
    check("t5_gnt", 32'(gnt), 0);
    check("t5_stb", 32'(s_stb), 0);
    check("t5_ack", 32'(m_ack), 0);
    check("t5_err", 32'(m_err), 0);
    rst = 1'b0; m_stb = '0; s_ack = 1'b0;
    step();
    // T6 random soak
    for (int k = 0; k < NM; k++) begin
      idx[k] = 0; gap[k] = 0;
      for (int t = 0; t < NT; t++) begin
        q_adr[k][t] = AW'($urandom); q_dat[k][t] = DW'($urandom); q_we[k][t] = 1'($urandom);
      end
    end
    do_reset();
    sl_wait = $urandom_range(0, 8);
    cyc = 0;
    while ((idx[0] < NT || idx[1] < NT) && cyc < 20000) begin
      for (int k = 0; k < NM; k++)
        if (idx[k] < NT && gap[k] == 0) begin
          m_stb[k] = 1'b1;
          m_we[k] = q_we[k][idx[k]];
          m_adr[k*AW +: AW] = q_adr[k][idx[k]];
          m_dat[k*DW +: DW] = q_dat[k][idx[k]];
        end else begin
          m_stb[k] = 1'b0;
          if (gap[k] > 0) gap[k]--;
        end
      #1;
      if (s_stb) begin
        if (sl_wait == 0) begin s_ack = 1'b1; sl_wait = $urandom_range(0, 8); end
        else begin s_ack = 1'b0; sl_wait--; end
      end else s_ack = 1'b0;
      s_rdat = DW'($urandom);
      #1;
      check("soak_err", 32'(m_err), 0);
      for (int k = 0; k < NM; k++)
        if (m_ack[k]) begin
          check("soak_adr", 32'(s_adr), 32'(q_adr[k][idx[k]]));
          check("soak_we", 32'(s_we), 32'(q_we[k][idx[k]]));
          if (q_we[k][idx[k]]) check("soak_wdat", 32'(s_wdat), 32'(q_dat[k][idx[k]]));
          idx[k]++;
          gap[k] = $urandom_range(0, 2);
        end
      step();
      cyc++;
    end
    check("soak_m0_done", 32'(idx[0]), NT);
    check("soak_m1_done", 32'(idx[1]), NT);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
